// File: rtl/pwm_decoder.sv
`timescale 1ns/1ps
// pwm_decoder: recovers the 4-bit duty value of a 16-slot PWM waveform.
// It synchronises pwm_in, measures the high time and the rise-to-rise period,
// and publishes the duty value with a one-cycle strobe. It also flags
// malformed periods and stuck-high lines, and reports duty 0 when the line
// stays low.
// Ports:
//   clk_3125KHz  system clock, rising edge
//   reset        synchronous active-high reset
//   pwm_in       PWM waveform, may be asynchronous
//   duty_cycle   last recovered duty value, held between updates
//   duty_valid   one-cycle strobe, duty_cycle updated
//   period_err   one-cycle strobe, bad period or stuck-high
//   locked       high while tracking a stable waveform
module pwm_decoder #(
  parameter int unsigned PERIOD      = 16,
  parameter int unsigned DUTY_W      = 4,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_3125KHz,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              duty_valid,
  output logic              period_err,
  output logic              locked
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] PER_C     = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    MEASURE = 2'd1,
    TRACK   = 2'd2
  } state_t;

  state_t state, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_pwm;
  logic                   s_prev;
  logic                   rise;
  logic                   per_ok;
  logic                   stuck_low;
  logic                   stuck_high;

  logic [CNT_W-1:0] per_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;

  logic [DUTY_W-1:0] duty_d;
  logic              valid_d;
  logic              err_d;

  // Input synchroniser plus one-cycle history for edge detection
  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      sync_q <= '0;
      s_prev <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_prev <= s_pwm;
    end
  end

  assign s_pwm  = sync_q[SYNC_STAGES-1];
  assign rise   = s_pwm & ~s_prev;
  assign per_ok = (per_cnt == PER_C);

  // low_cnt holds the previous low cycles, so this cycle is the PERIOD-th low
  assign stuck_low  = ~s_pwm & (low_cnt == TIMEOUT_C);
  // high_cnt only counts the high run that started at the last rise, so
  // reaching PERIOD highs without a rise means the line never dropped
  assign stuck_high = s_pwm & ~rise & (high_cnt == TIMEOUT_C);

  // Period, high-time and low-run counters
  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      per_cnt  <= '0;
      high_cnt <= '0;
      low_cnt  <= '0;
    end else begin
      if (rise) begin
        per_cnt  <= ONE_C;
        high_cnt <= ONE_C;
      end else begin
        per_cnt <= (per_cnt == CNT_MAX) ? per_cnt : per_cnt + ONE_C;
        if (s_pwm && (high_cnt != CNT_MAX)) begin
          high_cnt <= high_cnt + ONE_C;
        end
      end
      // Restart the low run after each stuck-low report so it repeats
      if (s_pwm || stuck_low) begin
        low_cnt <= '0;
      end else begin
        low_cnt <= low_cnt + ONE_C;
      end
    end
  end

  // State register
  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      state <= ACQUIRE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; a rise outranks the timeouts
  always_comb begin
    state_d = state;
    if (rise) begin
      unique case (state)
        ACQUIRE: state_d = MEASURE;
        MEASURE: state_d = per_ok ? TRACK : MEASURE;
        TRACK:   state_d = per_ok ? TRACK : MEASURE;
        default: state_d = ACQUIRE;
      endcase
    end else if (stuck_low || stuck_high) begin
      state_d = ACQUIRE;
    end
  end

  // Output decode; the first rise after acquire only opens a measurement
  always_comb begin
    duty_d  = duty_cycle;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (rise) begin
      if (state != ACQUIRE) begin
        if (per_ok) begin
          duty_d  = high_cnt[DUTY_W-1:0];
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (stuck_low) begin
      duty_d  = '0;
      valid_d = 1'b1;
    end else if (stuck_high) begin
      err_d = 1'b1;
    end
  end

  // Registered outputs
  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      duty_cycle <= '0;
      duty_valid <= 1'b0;
      period_err <= 1'b0;
      locked     <= 1'b0;
    end else begin
      duty_cycle <= duty_d;
      duty_valid <= valid_d;
      period_err <= err_d;
      locked     <= (state_d == TRACK);
    end
  end

endmodule

// File: doc/pwm_decoder.md
Name: pwm_decoder

Overview:
- Receives a 16-slot PWM waveform on one wire and recovers its 4-bit duty-cycle value.
- This is the receive end of the motor/LED PWM link. Any 16-cycle-period PWM source on the same 3.125 MHz clock domain, or an asynchronous source at the same nominal rate, can drive it.
- Measures the high time and the period between rising edges.
- Publishes the duty value with a one-cycle valid strobe and flags malformed periods.

Parameters:
- PERIOD, 16: expected PWM period in clock cycles. Must equal 2**DUTY_W.
- DUTY_W, 4: width of the recovered duty value.
- CNT_W, 5: width of the internal counters. Must satisfy 2**CNT_W > PERIOD.
- SYNC_STAGES, 2: number of flops in the pwm_in synchronizer. Must be 2 or more.

Ports:
- clk_3125KHz  input  1  system clock, 3.125 MHz; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pwm_in  input  1  incoming PWM waveform; may be asynchronous.
- duty_cycle  output  DUTY_W  last recovered duty value; holds between updates.
- duty_valid  output  1  one-cycle strobe; duty_cycle was updated this cycle.
- period_err  output  1  one-cycle strobe; malformed period or stuck-high detected.
- locked  output  1  level; 1 while in TRACK.

Behaviour:
- One clock domain; the reset is synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - Synchronizer flops, previous-sample flop and all counters are 0.
  - State is ACQUIRE.
- Reset asserted mid-period discards any partial measurement. No strobe fires on the reset cycle or on the cycle after it.
- Synchronizer:
  - s_pwm is pwm_in after SYNC_STAGES flops.
  - s_prev is s_pwm delayed by one cycle.
  - A rising edge (rise) is the cycle where s_pwm=1 and s_prev=0.
- Counters, updated every cycle:
  - On rise: per_cnt<=1, high_cnt<=1, low_cnt<=0.
  - Otherwise: per_cnt<=per_cnt+1 and high_cnt<=high_cnt+s_pwm, both saturating at 2**CNT_W-1.
  - low_cnt<=low_cnt+1 while s_pwm=0; low_cnt<=0 while s_pwm=1.
- State machine:
  - ACQUIRE: waiting for the first rising edge.
    - On rise: go to MEASURE. No output strobe.
  - MEASURE: first full period in progress; locked=0.
    - On rise with per_cnt==PERIOD: set duty_cycle<=high_cnt[DUTY_W-1:0], pulse duty_valid, go to TRACK.
    - On rise with per_cnt!=PERIOD: pulse period_err and stay in MEASURE, because this rise starts a fresh measurement.
  - TRACK: locked=1.
    - On rise with per_cnt==PERIOD: update duty_cycle and pulse duty_valid.
    - On rise with per_cnt!=PERIOD: pulse period_err, leave duty_cycle unchanged, go to MEASURE.
- Stuck-low (duty 0), checked in any state:
  - When low_cnt reaches PERIOD-1 and s_pwm=0 this cycle, the waveform has been low for PERIOD cycles.
  - Response: duty_cycle<=0, duty_valid=1, low_cnt<=0, state<=ACQUIRE, locked=0.
  - A continuous low therefore re-reports duty 0 every PERIOD cycles.
- Stuck-high:
  - If s_pwm has been 1 for PERIOD consecutive cycles (high_cnt==PERIOD with no intervening 0), pulse period_err once and go to ACQUIRE.
  - No further strobes until the next rise.
- Priority when events coincide in one cycle: reset > rise > stuck-low/stuck-high timeout.
- duty_valid and period_err are never asserted in the same cycle.
- Latency:
  - A pwm_in rising edge sampled at cycle k is the rise at cycle k+SYNC_STAGES.
  - duty_valid is registered and visible at k+SYNC_STAGES+1.
- Duty range:
  - 1..15 decodes from a normal period: high_cnt is 1..15 and the low time is 15..1.
  - A single-cycle low (duty 15) must still produce a rise.
  - Duty 0 is reported only through the stuck-low path.

Test Plan:
- Drive the matching PWM generator with duty=5. Expect:
  - First duty_valid on the second rise with duty_cycle=5.
  - locked=1 after that strobe.
  - One duty_valid every 16 cycles thereafter, period_err never set.
- Step duty 5 -> 15 -> 1 every 4 periods. Expect:
  - duty_cycle sequence 5, 15, 1, each on the first full period at the new value.
  - No period_err, including through the 1-cycle low of duty 15.
- Hold pwm_in low after lock. Expect:
  - duty_valid with duty_cycle=0 exactly 16 cycles after the last synchronized fall, repeating every 16 cycles.
  - locked=0.
  - Restarting duty=7 gives duty_valid=7 on the second rise.
- Hold pwm_in high for 20 cycles while in TRACK. Expect:
  - Exactly one period_err, 16 cycles after the rise.
  - locked=0.
  - duty_cycle keeps its old value.
- Inject a 12-cycle period (rise to rise) in TRACK. Expect period_err at that rise, no duty_valid, then relock with duty_valid 16 cycles later.
- Assert reset for 1 cycle mid-period at duty=9. Expect:
  - All outputs 0 on the next cycle.
  - No strobe until the second full rise after reset, which reports 9.
